// File: rtl/sequenciador_sel_mux.sv
// rtl/sequenciador_sel_mux.sv - select sequencer and per-channel sampler for the 2-channel mux.
// Optional round counter output n_ciclos is enabled by defining SEL_CYCLE_COUNT_EN.
module sequenciador_sel_mux #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         hold,
   input  logic [W-1:0] dwell0,
   input  logic [W-1:0] dwell1,
   input  logic         mux_out,
`ifdef SEL_CYCLE_COUNT_EN
   output logic [7:0]   n_ciclos,
`endif
   output logic         sel,
   output logic         sel_valid,
   output logic         troca,
   output logic         amostra0,
   output logic         amostra1,
   output logic         amostra_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CH0  = 2'd1,
      CH1  = 2'd2
   } state_t;

   state_t       state, state_n;
   logic [W-1:0] cnt, cnt_n;
   logic         troca_n, av_n, a0_n, a1_n;

   // A zero dwell still selects the channel for one cycle.
   function automatic logic [W-1:0] load_dwell(input logic [W-1:0] d);
      return (d == '0) ? W'(1) : d;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         troca         <= 1'b0;
         amostra_valid <= 1'b0;
         amostra0      <= 1'b0;
         amostra1      <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         troca         <= troca_n;
         amostra_valid <= av_n;
         amostra0      <= a0_n;
         amostra1      <= a1_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      troca_n = 1'b0;
      av_n    = 1'b0;
      a0_n    = amostra0;
      a1_n    = amostra1;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (en) begin
               state_n = CH0;
               cnt_n   = load_dwell(dwell0);
            end
         end
         CH0, CH1: begin
            if (!en) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (!hold) begin
               // Counter never goes below 1: the last dwell cycle reloads instead.
               if (cnt <= W'(1)) begin
                  troca_n = 1'b1;
                  av_n    = 1'b1;
                  if (state == CH0) begin
                     a0_n    = mux_out;
                     state_n = CH1;
                     cnt_n   = load_dwell(dwell1);
                  end else begin
                     a1_n    = mux_out;
                     state_n = CH0;
                     cnt_n   = load_dwell(dwell0);
                  end
               end else begin
                  cnt_n = cnt - W'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Select outputs come straight from the state register.
   assign sel       = (state == CH1);
   assign sel_valid = (state == CH0) || (state == CH1);

`ifdef SEL_CYCLE_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         n_ciclos <= 8'd0;
      end else if ((state == CH1) && (state_n == CH0) && (n_ciclos != 8'hFF)) begin
         n_ciclos <= n_ciclos + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sequenciador_sel_mux.sv
// tb/tb_sequenciador_sel_mux.sv - directed self-checking bench for sequenciador_sel_mux.
module tb_sequenciador_sel_mux;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, en, hold, inv;
   logic [W-1:0] dwell0, dwell1;
   logic         mux_out;
   logic         sel, sel_valid, troca, amostra0, amostra1, amostra_valid;
`ifdef SEL_CYCLE_COUNT_EN
   logic [7:0]   n_ciclos;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behaves like the companion mux with I0 = inv and I1 = ~inv.
   assign mux_out = sel ^ inv;

   sequenciador_sel_mux #(.W(W)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .hold(hold),
      .dwell0(dwell0),
      .dwell1(dwell1),
      .mux_out(mux_out),
`ifdef SEL_CYCLE_COUNT_EN
      .n_ciclos(n_ciclos),
`endif
      .sel(sel),
      .sel_valid(sel_valid),
      .troca(troca),
      .amostra0(amostra0),
      .amostra1(amostra1),
      .amostra_valid(amostra_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en    = 1'b0;
      hold  = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      inv = 1'b1; dwell0 = 8'd3; dwell1 = 8'd2;
      do_reset();
      checks++;
      if ({sel, sel_valid, troca, amostra0, amostra1, amostra_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset outputs got %b want 000000",
                  {sel, sel_valid, troca, amostra0, amostra1, amostra_valid});
      end
      tick();
      checks++;
      if (sel_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_sel_valid got %b want 0", sel_valid);
      end
   endtask

   task automatic test_sequence();
      logic [9:0] exp_sel = 10'b1100011000;
      logic [9:0] exp_tr  = 10'b0100101000;
      inv = 1'b1; dwell0 = 8'd3; dwell1 = 8'd2;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({sel, sel_valid, troca, amostra_valid} !== {exp_sel[i], 1'b1, exp_tr[i], exp_tr[i]}) begin
            errors++;
            $display("FAIL seq cycle %0d sel/valid/troca/av got %b want %b", i + 1,
                     {sel, sel_valid, troca, amostra_valid}, {exp_sel[i], 1'b1, exp_tr[i], exp_tr[i]});
         end
      end
      checks++;
      if ({amostra0, amostra1} !== 2'b10) begin
         errors++;
         $display("FAIL seq samples got %b want 10", {amostra0, amostra1});
      end
   endtask

   task automatic test_dwell_zero();
      inv = 1'b1; dwell0 = 8'd0; dwell1 = 8'd0;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({sel, troca} !== {(i % 2 == 1), (i != 0)}) begin
            errors++;
            $display("FAIL dwell0 cycle %0d sel/troca got %b want %b", i + 1,
                     {sel, troca}, {(i % 2 == 1), (i != 0)});
         end
      end
   endtask

   task automatic test_hold();
      inv = 1'b1; dwell0 = 8'd4; dwell1 = 8'd2;
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         hold = (i >= 2 && i <= 6);
         checks++;
         if (i <= 9) begin
            if ({sel, sel_valid, troca, amostra_valid} !== 4'b0100) begin
               errors++;
               $display("FAIL hold cycle %0d sel/valid/troca/av got %b want 0100", i,
                        {sel, sel_valid, troca, amostra_valid});
            end
         end else if ({sel, troca, amostra_valid} !== 3'b111) begin
            errors++;
            $display("FAIL hold switch got %b want 111", {sel, troca, amostra_valid});
         end
      end
      hold = 1'b0;
   endtask

   task automatic test_en_drop();
      inv = 1'b1; dwell0 = 8'd1; dwell1 = 8'd2;
      do_reset();
      en = 1'b1;
      tick(); tick(); tick();
      checks++;
      if ({sel, amostra0, amostra1} !== 3'b110) begin
         errors++;
         $display("FAIL en_drop pre got %b want 110", {sel, amostra0, amostra1});
      end
      // Drop en on the last CH1 cycle with hold also high and mux_out now 1.
      en = 1'b0; hold = 1'b1; inv = 1'b0;
      tick();
      checks++;
      if ({sel, sel_valid, troca, amostra0, amostra1, amostra_valid} !== 6'b000100) begin
         errors++;
         $display("FAIL en_drop got %b want 000100",
                  {sel, sel_valid, troca, amostra0, amostra1, amostra_valid});
      end
      hold = 1'b0; en = 1'b1; dwell0 = 8'd5;
      tick(); tick();
      checks++;
      if ({sel, sel_valid, amostra0} !== 3'b011) begin
         errors++;
         $display("FAIL reenter got %b want 011", {sel, sel_valid, amostra0});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; en = 1'b0;
      checks++;
      if ({sel, sel_valid, troca, amostra0, amostra1, amostra_valid} !== 6'b0) begin
         errors++;
         $display("FAIL midreset got %b want 000000",
                  {sel, sel_valid, troca, amostra0, amostra1, amostra_valid});
      end
   endtask

`ifdef SEL_CYCLE_COUNT_EN
   task automatic test_cycle_count();
      inv = 1'b1; dwell0 = 8'd1; dwell1 = 8'd1;
      do_reset();
      en = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (n_ciclos !== 8'd1) begin
         errors++;
         $display("FAIL n_ciclos first got %0d want 1", n_ciclos);
      end
      repeat (600) tick();
      checks++;
      if (n_ciclos !== 8'd255) begin
         errors++;
         $display("FAIL n_ciclos sat got %0d want 255", n_ciclos);
      end
      en = 1'b0;
      tick(); tick();
      checks++;
      if (n_ciclos !== 8'd255) begin
         errors++;
         $display("FAIL n_ciclos en0 got %0d want 255", n_ciclos);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; en = 1'b0; hold = 1'b0; inv = 1'b1;
      dwell0 = '0; dwell1 = '0;
      test_reset();
      test_sequence();
      test_dwell_zero();
      test_hold();
      test_en_drop();
`ifdef SEL_CYCLE_COUNT_EN
      test_cycle_count();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequenciador_sel_mux.md
Name: sequenciador_sel_mux

Overview:
- Upstream and downstream companion of the 2-channel mux (mux_2canais).
- Drives the mux select line, alternating channel 0 and channel 1. Each channel is held for a programmable dwell time in clock cycles.
- Samples the mux output (s_out) on the last cycle of each dwell and presents one registered sample per channel.
- Turns the static mux into a time-multiplexed 2-channel acquisition path.

Parameters:
- W, 8, width of the dwell counters and of the dwell0/dwell1 inputs.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  run enable. 1 = sequence channels; 0 = return to idle.
- hold  input  1  freeze: dwell counter and sel hold their values while 1.
- dwell0  input  W  dwell length for channel 0, in cycles.
- dwell1  input  W  dwell length for channel 1, in cycles.
- mux_out  input  1  mux output (s_out), fed back for sampling.
- sel  output  1  mux select (0 = I0, 1 = I1).
- sel_valid  output  1  1 while a channel is actively selected (states CH0/CH1).
- troca  output  1  one-cycle pulse on the first cycle after sel changes channel.
- amostra0  output  1  last sampled mux_out for channel 0.
- amostra1  output  1  last sampled mux_out for channel 1.
- amostra_valid  output  1  one-cycle pulse when amostra0 or amostra1 updates.

Behaviour:
- Reset (synchronous, highest priority, valid mid-operation):
  - state=IDLE, counter=0.
  - sel=0, sel_valid=0, troca=0, amostra0=0, amostra1=0, amostra_valid=0.
- All outputs are registered.
- State machine has three states: IDLE, CH0, CH1.
- IDLE:
  - sel=0, sel_valid=0.
  - en=1 -> CH0 on the next edge; counter loads dwell0.
  - troca is not pulsed on the IDLE->CH0 entry.
- CH0 / CH1:
  - sel=0 / sel=1, sel_valid=1.
  - Counter is loaded with dwellX on entry. dwellX=0 is treated as 1.
  - Changes to dwellX while in a state take effect only at the next entry to that state.
  - hold=0: counter decrements each cycle.
  - hold=1: counter, sel and state are frozen; no sample, no troca.
- Last dwell cycle (counter==1, hold=0, en=1):
  - mux_out is captured into amostraX, visible on the next cycle.
  - amostra_valid pulses for 1 cycle, coincident with the new amostraX value.
  - State moves to the other channel; counter loads the other channel's dwell.
  - troca=1 for exactly the first cycle of the new channel.
- Dwell timing: a channel stays selected for exactly max(dwellX,1) unheld cycles.
- en=0 in CH0/CH1:
  - Next edge -> IDLE, sel=0, sel_valid=0.
  - No sample is taken, even if this is the last dwell cycle.
  - amostra0/amostra1 retain their values.
- Simultaneous en=0 and hold=1: en=0 wins.
- Counter arithmetic is W-bit unsigned with no wrap: it reloads at 1 and never decrements below 1.

Optional Feature:
- Macro: SEL_CYCLE_COUNT_EN.
- Defined:
  - Adds output n_ciclos, 8 bits: number of completed CH0->CH1->CH0 rounds.
  - Increments on each CH1->CH0 transition and saturates at 255.
  - Cleared by reset; not cleared by en=0.
- Undefined: port n_ciclos and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then en=1, dwell0=3, dwell1=2, hold=0 -> sel pattern 0,0,0,1,1,0,0,0,...; troca pulses on the first cycle of each new channel; sel_valid=1 from the cycle after en rises.
- Same config, mux_out=sel ^ 1 -> amostra0=1 and amostra1=0 after the first round; amostra_valid pulses twice per round, on the cycle after each dwell end.
- dwell0=0, dwell1=0 -> sel toggles every cycle, troca=1 every cycle after the first switch.
- dwell0=4, hold=1 for 5 cycles mid-CH0 -> CH0 lasts 9 cycles total; no troca and no amostra_valid during the hold.
- en dropped on the last CH1 cycle -> next cycle IDLE, sel=0, sel_valid=0, amostra1 unchanged. Then reset asserted mid-CH0 -> all outputs 0 on the next edge.
- SEL_CYCLE_COUNT_EN defined, dwell0=dwell1=1, 600 cycles -> n_ciclos saturates at 255 and stays there.
